// File: rtl/uart_pkg.sv
// Shared UART framing constants and TX FSM state encodings.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ALIGN  = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i, wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    always_comb begin
        logic           found;
        int             j;
        logic [IDW-1:0] jj;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = IDW'(j);
            if (!found && req_i[jj]) begin
                found     = 1'b1;
                gnt_o[jj] = 1'b1;
                idx_o     = jj;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TX line among NREQ byte producers.
// Define UART_TX_PARITY_EN for an even-parity bit after bit 7 (11-bit frames); otherwise 10-bit frames.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx,
    output logic              busy,
    output logic [IDW-1:0]    gnt_id,
    output logic              done
);

    logic [2:0]                state_q, state_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic [NREQ-1:0]           rdy_q, rdy_d;
    logic                      done_q, done_d;
    logic [IDW-1:0]            gnt_q, gnt_d;
    logic [IDW-1:0]            ptr_q, ptr_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic                      par_q, par_d;
`endif

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_idx;
    logic            arb_any;
    logic [7:0]      req_byte [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) req_byte[i] = req_data[8*i +: 8];
    end

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        rdy_d   = '0;
        done_d  = 1'b0;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    rdy_d   = arb_gnt;
                    shift_d = req_byte[arb_idx];
                    gnt_d   = arb_idx;
                    ptr_d   = (arb_idx == IDW'(NREQ-1)) ? '0 : arb_idx + IDW'(1);
                    busy_d  = 1'b1;
                    state_d = ST_ALIGN;
                end
            end
            // A tick landing in the accept cycle (ready still high) would start a short bit; skip it.
            ST_ALIGN: begin
                if (baud_tick && (rdy_q == '0)) begin
                    tx_d    = UART_START_LVL;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = shift_q[0];
`endif
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (cnt_q == 3'(UART_DATA_BITS-1)) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = UART_IDLE_LVL;
                        state_d = ST_STOP;
`endif
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                        par_d   = par_q ^ shift_q[0];
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    tx_d    = UART_IDLE_LVL;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_d    = UART_IDLE_LVL;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tx_q    <= UART_IDLE_LVL;
            busy_q  <= 1'b0;
            rdy_q   <= '0;
            done_q  <= 1'b0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath only; always loaded before use, so no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        par_q   <= par_d;
`endif
    end

    assign req_ready = rdy_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign gnt_id    = gnt_q;
    assign done      = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: frame-level reference model, per-cycle compare, line decoder.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef UART_TX_PARITY_EN
    localparam int          NB       = 11;
    localparam logic [10:0] FRAME_AB = 11'h756;
`else
    localparam int          NB       = 10;
    localparam logic [10:0] FRAME_AB = 11'h356;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              baud_tick = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx;
    logic              busy;
    logic [IDW-1:0]    gnt_id;
    logic              done;

    uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .gnt_id    (gnt_id),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [8*NREQ-1:0] d, input int i);
        return d[8*i +: 8];
    endfunction

    // Bit i of a frame as it must appear on the line: start, data LSB first, [even parity], stop.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[3'(i-1)];
        if (NB == 11 && i == 9) return ^b;
        return 1'b1;
    endfunction

    // ---------------- stimulus driver (requesters + baud ticks) ----------------
    int          mode = 2;            // 1: scripted requests, 2: random requesters
    logic        force_tick = 1'b0;
    int          forced_cnt = 0;
    int          pend_req [NREQ] = '{default: 0};
    logic [7:0]  pend_data [NREQ] = '{default: 8'h00};
    int          sent [NREQ] = '{default: 0};
    logic        rnd_valid [NREQ] = '{default: 1'b0};
    logic [7:0]  rnd_data [NREQ] = '{default: 8'h00};
    int          tcnt = 4;
    logic [7:0]  acc_q [$];

    always @(negedge clk) begin
        logic tk;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                acc_q.push_back(byte_of(req_data, i));
                sent[i]++;
                rnd_valid[i] = 1'b0;
            end
            if (!rnd_valid[i] && $urandom_range(7) == 0) begin
                rnd_valid[i] = 1'b1;
                rnd_data[i]  = 8'($urandom);
            end else if (rnd_valid[i] && !req_ready[i] && $urandom_range(63) == 0) begin
                rnd_valid[i] = 1'b0;
            end
            if (mode == 2) begin
                req_valid[i]        = rnd_valid[i];
                req_data[8*i +: 8]  = rnd_data[i];
            end else begin
                req_valid[i]        = (sent[i] < pend_req[i]);
                req_data[8*i +: 8]  = pend_data[i];
            end
        end
        tk = 1'b0;
        if (force_tick && req_ready != '0) begin
            tk = 1'b1;
            forced_cnt++;
        end else if (tcnt == 0) begin
            tk = 1'b1;
        end
        if (tk) tcnt = (mode == 2) ? int'($urandom_range(6, 1)) : 4;
        else    tcnt--;
        baud_tick = tk;
    end

    // ---------------- reference model (frame level) ----------------
    logic            m_busy = 1'b0;
    logic            m_first = 1'b0;
    int              m_ptr = 0;
    int              m_gnt = 0;
    int              m_k = 0;
    logic [7:0]      m_byte = 8'h00;
    logic            exp_tx = 1'b1;
    logic [NREQ-1:0] exp_rdy = '0;
    logic            exp_done = 1'b0;
    logic            tick_s = 1'b0;

    always @(posedge clk) begin
        tick_s = baud_tick;
        if (!rst) begin
            m_busy = 1'b0; m_first = 1'b0; m_ptr = 0; m_gnt = 0; m_k = 0;
            exp_tx = 1'b1; exp_rdy = '0; exp_done = 1'b0;
        end else begin
            exp_rdy  = '0;
            exp_done = 1'b0;
            if (!m_busy) begin
                if (req_valid != '0) begin
                    int g;
                    g = -1;
                    for (int k = 0; k < NREQ; k++) begin
                        int ix;
                        ix = (m_ptr + k) % NREQ;
                        if (g < 0 && req_valid[2'(ix)]) g = ix;
                    end
                    m_gnt   = g;
                    m_ptr   = (g + 1) % NREQ;
                    m_byte  = byte_of(req_data, g);
                    m_busy  = 1'b1;
                    m_first = 1'b1;
                    m_k     = 0;
                    exp_rdy[2'(g)] = 1'b1;
                end
            end else begin
                if (baud_tick && !m_first) begin
                    m_k++;
                    if (m_k <= NB) begin
                        exp_tx = frame_bit(m_byte, m_k - 1);
                    end else begin
                        exp_done = 1'b1;
                        m_busy   = 1'b0;
                        exp_tx   = 1'b1;
                    end
                end
                m_first = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_gnt", 32'(gnt_id), 32'd0);
        end else begin
            chk("tx", 32'(tx), 32'(exp_tx));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("done", 32'(done), 32'(exp_done));
            if (busy) chk("gnt_id", 32'(gnt_id), 32'(m_gnt));
        end
    end

    // ---------------- line decoder / monitors ----------------
    logic        dec_active = 1'b0;
    int          dec_cnt = 0;
    logic [10:0] dec_vec = '0;
    logic [10:0] frames_q [$];
    logic [1:0]  gnt_log [$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            dec_active = 1'b0;
            dec_cnt    = 0;
        end else begin
            if (done) done_cnt++;
            if (req_ready != '0) gnt_log.push_back(gnt_id);
            if (tick_s) begin
                if (!dec_active) begin
                    if (tx == 1'b0) begin
                        dec_active = 1'b1;
                        dec_vec    = '0;
                        dec_cnt    = 1;
                    end
                end else begin
                    dec_vec[4'(dec_cnt)] = tx;
                    dec_cnt++;
                    if (dec_cnt == NB) begin
                        frames_q.push_back(dec_vec);
                        dec_active = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- sequence ----------------
    int f0, g0, d0, a0;

    task automatic mark();
        f0 = frames_q.size(); g0 = gnt_log.size(); d0 = done_cnt; a0 = acc_q.size();
    endtask

    task automatic reset_pulse();
        @(negedge clk); #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget, input string nm);
        int c;
        c = 0;
        while (frames_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(nm, 32'(frames_q.size() >= n), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, bad, n, na;
        logic [7:0] b;
        int exp_g [5];

        // Reset held with random requesters active
        rst = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        chk("reset_tx_hold", 32'(tx), 32'd1);
        chk("reset_busy_hold", 32'(busy), 32'd0);
        chk("reset_ready_hold", 32'(req_ready), 32'd0);
        mode = 1;
        @(negedge clk); #2 rst = 1'b1;

        // Single frame 8'hAB from requester 0
        mark();
        pend_data[0] = 8'hAB; pend_req[0] = sent[0] + 1;
        wait_frames(f0 + 1, 400, "single_timeout");
        repeat (15) @(negedge clk);
        chk("single_frame_bits", 32'(frames_q[f0]), 32'(FRAME_AB));
        b = frames_q[f0][8:1];
        chk("single_byte", 32'(b), 32'h0AB);
        chk("single_done_once", 32'(done_cnt - d0), 32'd1);
        chk("single_gnt", 32'(gnt_log[g0]), 32'd0);

        // All requesters valid: rotation 0,1,2,3,0
        reset_pulse();
        mark();
        for (int i = 0; i < NREQ; i++) begin
            pend_data[i] = 8'h10 + 8'(i);
            pend_req[i]  = sent[i] + ((i == 0) ? 2 : 1);
        end
        wait_frames(f0 + 5, 1500, "rr_timeout");
        for (int k = 0; k < 5; k++) begin
            chk("rr_gnt", 32'(gnt_log[g0 + k]), 32'(k % 4));
            b = frames_q[f0 + k][8:1];
            chk("rr_byte", 32'(b), 32'h10 + 32'(k % 4));
        end

        // Sparse rotation: grant 2, then only 1 and 3 -> 3 then 1
        reset_pulse();
        mark();
        pend_data[2] = 8'h22; pend_req[2] = sent[2] + 1;
        c = 0;
        while (gnt_log.size() <= g0 && c < 200) begin @(negedge clk); c++; end
        pend_data[1] = 8'h31; pend_req[1] = sent[1] + 1;
        pend_data[3] = 8'h33; pend_req[3] = sent[3] + 1;
        wait_frames(f0 + 3, 1200, "sparse_timeout");
        exp_g = '{2, 3, 1, 0, 0};
        for (int k = 0; k < 3; k++) chk("sparse_gnt", 32'(gnt_log[g0 + k]), 32'(exp_g[k]));
        b = frames_q[f0 + 1][8:1];
        chk("sparse_byte3", 32'(b), 32'h33);

        // Tick forced into the accept cycle
        reset_pulse();
        mark();
        c = forced_cnt;
        force_tick = 1'b1;
        pend_data[1] = 8'h3C; pend_req[1] = sent[1] + 1;
        wait_frames(f0 + 1, 400, "acctick_timeout");
        force_tick = 1'b0;
        chk("acctick_forced", 32'(forced_cnt > c), 32'd1);
        b = frames_q[f0][8:1];
        chk("acctick_byte", 32'(b), 32'h3C);

        // Reset while data bit 4 is on the line
        reset_pulse();
        mark();
        pend_data[0] = 8'h5A; pend_req[0] = sent[0] + 1;
        c = 0;
        while (!(dec_active && dec_cnt == 6) && c < 400) begin @(negedge clk); c++; end
        chk("midreset_reach", 32'(c < 400), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midreset_tx", 32'(tx), 32'd1);
        chk("midreset_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy || tx == 1'b0) bad++;
        end
        chk("midreset_idle", 32'(bad), 32'd0);
        chk("midreset_no_frame", 32'(frames_q.size() - f0), 32'd0);

        // Random requesters and random tick spacing
        reset_pulse();
        mark();
        mode = 2;
        repeat (4000) @(negedge clk);
        mode = 1;
        repeat (5) @(negedge clk);
        c = 0;
        while (busy && c < 300) begin @(negedge clk); c++; end
        chk("rand_drain", 32'(busy), 32'd0);
        n  = frames_q.size() - f0;
        na = acc_q.size() - a0;
        chk("rand_count", 32'(n), 32'(na));
        chk("rand_enough", 32'(n > 10), 32'd1);
        for (int k = 0; k < n && k < na; k++) begin
            b = frames_q[f0 + k][8:1];
            chk("rand_byte", 32'(b), 32'(acc_q[a0 + k]));
            if (NB == 11) chk("rand_parity", 32'(frames_q[f0 + k][9]), 32'(^b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
